fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter D, default 10: program-counter width; instruction ROM depth is 2**D words.
REQ-002 Parameter CW, default 16: cycle-counter width (used only when FETCH_CYCLE_CNT_EN is defined).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  one-cycle pulse; begins a program run from address 0.
REQ-006 Stall  input  1  holds the PC for the current cycle.
REQ-007 JumpEn  input  1  absolute jump request.
REQ-008 JumpAddr  input  D  absolute jump target.
REQ-009 BranchEn  input  1  taken relative-branch request.
REQ-010 BranchOff  input  D  two's-complement branch offset relative to current PC.
REQ-011 HaltReq  input  1  decoder-detected halt instruction.
REQ-012 prog_ctr  output  D  instruction ROM address.
REQ-013 Running  output  1  high while in RUN.
REQ-014 Done  output  1  high while in HALTED.
REQ-015 Cycles  output  CW  RUN-cycle count (present only with FETCH_CYCLE_CNT_EN).

Function
REQ-016 FSM states: IDLE, RUN, HALTED; Running = (state==RUN), Done = (state==HALTED), both registered-state decodes.
REQ-017 IDLE: Start -> RUN with prog_ctr <= 0; all other inputs ignored.
REQ-018 RUN, per-cycle priority: HaltReq > Stall > JumpEn > BranchEn > sequential.
REQ-019 RUN with HaltReq -> HALTED; prog_ctr holds.
REQ-020 RUN with Stall (no HaltReq): prog_ctr holds, state stays RUN.
REQ-021 RUN with JumpEn: prog_ctr <= JumpAddr next cycle.
REQ-022 RUN with BranchEn: prog_ctr <= (prog_ctr + BranchOff) mod 2**D.
REQ-023 RUN otherwise: prog_ctr <= (prog_ctr + 1) mod 2**D; 2**D-1 wraps to 0, no error flag.
REQ-024 Start while in RUN is ignored.
REQ-025 HALTED: prog_ctr and Done hold until Start; Start -> RUN, prog_ctr <= 0, Done low next cycle.
REQ-026 Latency: a redirect asserted in cycle N is visible on prog_ctr in cycle N+1; prog_ctr is a direct register output with no combinational input path.
REQ-027 Simultaneous JumpEn and BranchEn: jump wins and the branch is discarded.

Reset
REQ-028 Reset_n low asynchronously forces state IDLE, prog_ctr 0, Running 0, Done 0, Cycles 0.
REQ-029 Reset mid-run aborts the run; after release the block waits in IDLE for Start.
REQ-030 Reset_n deassertion is synchronised externally; the block performs no internal synchronisation.

Configuration
REQ-031 Macro FETCH_CYCLE_CNT_EN defined: Cycles port and counter exist; counter clears on the accepted Start, increments every RUN cycle including stalls, saturates at 2**CW-1, and holds in HALTED.
REQ-032 Macro FETCH_CYCLE_CNT_EN undefined: no Cycles port and no counter logic; all other behaviour identical.

Structure
REQ-033 Shared package fetch_pkg holds the state enum (IDLE, RUN, HALTED) and the default D constant shared with the instruction ROM.
REQ-034 Single flat module; no sub-module required (the next-PC mux stays inline).

Verification
REQ-035 Reset, then Start pulse, no redirects, 5 cycles -> prog_ctr 0,1,2,3,4; Running=1, Done=0.
REQ-036 At PC=5 assert JumpEn with JumpAddr=0x200 and BranchEn with BranchOff=3 together -> next prog_ctr=0x200.
REQ-037 At PC=10 assert BranchEn with BranchOff=0x3FD (-3, D=10) -> next prog_ctr=7; at PC=0x3FF with no redirect -> next prog_ctr=0.
REQ-038 At PC=20 assert Stall for 3 cycles, then HaltReq together with JumpEn -> prog_ctr stays 20, Done=1; with the counter enabled Cycles=24; a later Start -> prog_ctr=0, Done=0, Cycles=0.
REQ-039 At PC=50 drive Reset_n low between clock edges -> prog_ctr=0 and state IDLE immediately; after release, no Start for 4 cycles -> prog_ctr stays 0, Running=0.
REQ-040 CW=4, counter enabled, run 20 cycles -> Cycles saturates at 15; build without the macro -> Cycles port absent and elaboration clean.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch definitions: controller state encoding and default PC width
// (the instruction ROM is sized from the same constant).
package fetch_pkg;

    localparam int D_DEF = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch controller: IDLE/RUN/HALTED sequencing of the instruction ROM address.
// Optional RUN-cycle counter on the Cycles port when FETCH_CYCLE_CNT_EN is defined.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int D  = D_DEF,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic          Stall,
    input  logic          JumpEn,
    input  logic [D-1:0]  JumpAddr,
    input  logic          BranchEn,
    input  logic [D-1:0]  BranchOff,
    input  logic          HaltReq,
    output logic [D-1:0]  prog_ctr,
    output logic          Running,
    output logic          Done
`ifdef FETCH_CYCLE_CNT_EN
    ,
    output logic [CW-1:0] Cycles
`endif
);

    if (D < 1 || CW < 1) begin : g_param_check
        $error("fetch_ctrl: D and CW must be at least 1");
    end

    localparam logic [D-1:0] PC_ONE = {{(D-1){1'b0}}, 1'b1};

    state_t       state, state_n;
    logic [D-1:0] pc_q, pc_n;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            pc_q  <= '0;
        end else begin
            state <= state_n;
            pc_q  <= pc_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        unique case (state)
            IDLE, HALTED: begin
                if (Start) begin
                    state_n = RUN;
                    pc_n    = '0;
                end
            end
            RUN: begin
                // halt freezes the PC; jump beats branch
                if (HaltReq) begin
                    state_n = HALTED;
                end else if (Stall) begin
                    pc_n = pc_q;
                end else if (JumpEn) begin
                    pc_n = JumpAddr;
                end else if (BranchEn) begin
                    pc_n = pc_q + BranchOff;
                end else begin
                    pc_n = pc_q + PC_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                pc_n    = '0;
            end
        endcase
    end

    assign prog_ctr = pc_q;
    assign Running  = (state == RUN);
    assign Done     = (state == HALTED);

`ifdef FETCH_CYCLE_CNT_EN
    localparam logic [CW-1:0] CYC_MAX = '1;
    localparam logic [CW-1:0] CYC_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cyc_q;
    logic          start_acc;

    assign start_acc = Start && (state != RUN);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cyc_q <= '0;
        end else if (start_acc) begin
            cyc_q <= '0;
        end else if (state == RUN && cyc_q != CYC_MAX) begin
            cyc_q <= cyc_q + CYC_ONE;
        end
    end

    assign Cycles = cyc_q;
`endif

endmodule
